pm_resp_queue_stage: RTL and testbench

- Parametrised pre-memory pipeline stage, placed between the execute stage and the memory stage.
- Allows up to DEPTH data-bus requests to be outstanding at once.
- Buffers in-order data_data_ok responses in a FIFO and pairs each one with the load or store that owns it, in program order.
- On a pipeline flush, drops the responses of cancelled requests so later instructions never receive stale read data.

---
 rtl/pm_resp_queue_stage.sv | 190 +++++++++++++++++++
 tb/tb_pm_resp_queue_stage.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pm_resp_queue_stage.sv
// pm_resp_queue_stage: pre-memory pipeline stage between execute and memory.
// Lets up to DEPTH data-bus requests be outstanding, buffers the in-order
// data_data_ok beats in a FIFO and hands the head beat to the load/store
// currently held in this stage. Beats that belong to requests cancelled by a
// flush are counted and dropped when they arrive.
//
// Ports:
//   clk, resetn                     clock, synchronous active-low reset
//   exe_to_pm_valid, exe_*          instruction presented by execute
//   pm_allowin                      stage can accept an instruction
//   data_req_fire / data_req_allow  bus request accepted / may issue request
//   data_data_ok, data_rdata        response beat and its data
//   flush                           kill this stage and in-flight younger work
//   mem_allowin                     memory stage can accept
//   pm_valid, pm_*                  registered instruction payload
//   pm_rdata                        head of the response FIFO
//   pm_to_mem_valid                 hand-off to the memory stage
module pm_resp_queue_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 20,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              exe_to_pm_valid,
    input  logic [DATA_W-1:0] exe_pc,
    input  logic [DATA_W-1:0] exe_inst,
    input  logic [OP_W-1:0]   exe_op,
    input  logic [4:0]        exe_dest,
    input  logic [DATA_W-1:0] exe_value,
    input  logic [6:0]        exe_exc,
    output logic              pm_allowin,
    input  logic              data_req_fire,
    output logic              data_req_allow,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic              flush,
    input  logic              mem_allowin,
    output logic              pm_valid,
    output logic [DATA_W-1:0] pm_pc,
    output logic [DATA_W-1:0] pm_inst,
    output logic [DATA_W-1:0] pm_value,
    output logic [OP_W-1:0]   pm_op,
    output logic [4:0]        pm_dest,
    output logic [6:0]        pm_exc,
    output logic [DATA_W-1:0] pm_rdata,
    output logic              pm_to_mem_valid
);

    localparam int unsigned       CW       = $clog2(DEPTH) + 1;
    localparam int unsigned       PW       = $clog2(DEPTH);
    localparam logic [CW:0]       DEPTH_L  = (CW+1)'(DEPTH);
    localparam logic [DATA_W-1:0] RESET_PC = DATA_W'(32'hbfc00000);

    logic              pm_valid_q, pm_valid_d;
    logic [DATA_W-1:0] pm_pc_q, pm_pc_d;
    logic [DATA_W-1:0] pm_inst_q, pm_inst_d;
    logic [DATA_W-1:0] pm_value_q, pm_value_d;
    logic [OP_W-1:0]   pm_op_q, pm_op_d;
    logic [4:0]        pm_dest_q, pm_dest_d;
    logic [6:0]        pm_exc_q, pm_exc_d;

    logic [CW-1:0]     out_cnt_q, out_cnt_d;
    logic [CW-1:0]     disc_cnt_q, disc_cnt_d;
    logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] fifo_mem_q [DEPTH];
    logic [DATA_W-1:0] fifo_mem_d [DEPTH];

    logic is_mem;
    logic pm_ready_go;
    logic push;
    logic drop;
    logic pop;
    logic load_payload;

    // Handshake and FIFO control
    always_comb begin
        is_mem          = (|(pm_op_q[9:7] | pm_op_q[6:4])) && !pm_exc_q[6];
        pm_ready_go     = !is_mem || (fifo_cnt_q != '0);
        pm_allowin      = !pm_valid_q || (pm_ready_go && mem_allowin);
        pm_to_mem_valid = pm_valid_q && pm_ready_go && !flush;
        // Counting buffered beats as well as outstanding ones guarantees
        // every future beat finds a free FIFO slot.
        data_req_allow  = ({1'b0, out_cnt_q} + {1'b0, fifo_cnt_q}) < DEPTH_L;
        push            = data_data_ok && (disc_cnt_q == '0) && !flush;
        drop            = data_data_ok && (disc_cnt_q != '0);
        // A store's beat is consumed too; its data is simply not used.
        pop             = pm_to_mem_valid && mem_allowin && is_mem;
        load_payload    = exe_to_pm_valid && pm_allowin && !flush;
    end

    // Next-state computation
    always_comb begin
        pm_valid_d = pm_valid_q;
        pm_pc_d    = pm_pc_q;
        pm_inst_d  = pm_inst_q;
        pm_value_d = pm_value_q;
        pm_op_d    = pm_op_q;
        pm_dest_d  = pm_dest_q;
        pm_exc_d   = pm_exc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        disc_cnt_d = disc_cnt_q;
        fifo_mem_d = fifo_mem_q;

        out_cnt_d = out_cnt_q + CW'(data_req_fire) - CW'(data_data_ok);

        if (flush) begin
            pm_valid_d = 1'b0;
            fifo_cnt_d = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // Every request still outstanding after this edge, including
            // one fired right now, will return a beat that must be dropped.
            disc_cnt_d = disc_cnt_q + out_cnt_d;
        end else begin
            if (pm_allowin) begin
                pm_valid_d = exe_to_pm_valid;
            end
            if (load_payload) begin
                pm_pc_d    = exe_pc;
                pm_inst_d  = exe_inst;
                pm_value_d = exe_value;
                pm_op_d    = exe_op;
                pm_dest_d  = exe_dest;
                pm_exc_d   = exe_exc;
            end
            if (drop) begin
                disc_cnt_d = disc_cnt_q - CW'(1);
            end
            if (push) begin
                fifo_mem_d[wr_ptr_q] = data_rdata;
                wr_ptr_d             = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pm_valid_q <= 1'b0;
            pm_pc_q    <= RESET_PC;
            pm_inst_q  <= '0;
            pm_value_q <= '0;
            pm_op_q    <= '0;
            pm_dest_q  <= '0;
            pm_exc_q   <= '0;
            out_cnt_q  <= '0;
            disc_cnt_q <= '0;
            fifo_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            pm_valid_q <= pm_valid_d;
            pm_pc_q    <= pm_pc_d;
            pm_inst_q  <= pm_inst_d;
            pm_value_q <= pm_value_d;
            pm_op_q    <= pm_op_d;
            pm_dest_q  <= pm_dest_d;
            pm_exc_q   <= pm_exc_d;
            out_cnt_q  <= out_cnt_d;
            disc_cnt_q <= disc_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_mem_q[i] <= fifo_mem_d[i];
            end
        end
    end

    assign pm_valid = pm_valid_q;
    assign pm_pc    = pm_pc_q;
    assign pm_inst  = pm_inst_q;
    assign pm_value = pm_value_q;
    assign pm_op    = pm_op_q;
    assign pm_dest  = pm_dest_q;
    assign pm_exc   = pm_exc_q;
    assign pm_rdata = fifo_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_pm_resp_queue_stage.sv
// Self-checking bench for pm_resp_queue_stage: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_pm_resp_queue_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 20;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              exe_to_pm_valid;
    logic [DATA_W-1:0] exe_pc, exe_inst, exe_value;
    logic [OP_W-1:0]   exe_op;
    logic [4:0]        exe_dest;
    logic [6:0]        exe_exc;
    logic              pm_allowin;
    logic              data_req_fire;
    logic              data_req_allow;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;
    logic              flush;
    logic              mem_allowin;
    logic              pm_valid;
    logic [DATA_W-1:0] pm_pc, pm_inst, pm_value;
    logic [OP_W-1:0]   pm_op;
    logic [4:0]        pm_dest;
    logic [6:0]        pm_exc;
    logic [DATA_W-1:0] pm_rdata;
    logic              pm_to_mem_valid;

    always #5 clk = ~clk;

    pm_resp_queue_stage #(
        .DATA_W(DATA_W),
        .OP_W  (OP_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .exe_to_pm_valid(exe_to_pm_valid),
        .exe_pc         (exe_pc),
        .exe_inst       (exe_inst),
        .exe_op         (exe_op),
        .exe_dest       (exe_dest),
        .exe_value      (exe_value),
        .exe_exc        (exe_exc),
        .pm_allowin     (pm_allowin),
        .data_req_fire  (data_req_fire),
        .data_req_allow (data_req_allow),
        .data_data_ok   (data_data_ok),
        .data_rdata     (data_rdata),
        .flush          (flush),
        .mem_allowin    (mem_allowin),
        .pm_valid       (pm_valid),
        .pm_pc          (pm_pc),
        .pm_inst        (pm_inst),
        .pm_value       (pm_value),
        .pm_op          (pm_op),
        .pm_dest        (pm_dest),
        .pm_exc         (pm_exc),
        .pm_rdata       (pm_rdata),
        .pm_to_mem_valid(pm_to_mem_valid)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: stage contents, outstanding/discard counts, beat queue.
    logic              m_valid;
    logic [DATA_W-1:0] m_pc, m_inst, m_value;
    logic [OP_W-1:0]   m_op;
    logic [4:0]        m_dest;
    logic [6:0]        m_exc;
    int                m_out;
    int                m_disc;
    logic [DATA_W-1:0] m_q [$];

    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(20'h00020);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(20'h00100);
    localparam logic [OP_W-1:0] OP_ALU   = OP_W'(20'h00005);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_pc    = 32'hbfc00000;
        m_inst  = '0;
        m_value = '0;
        m_op    = '0;
        m_dest  = '0;
        m_exc   = '0;
        m_out   = 0;
        m_disc  = 0;
        m_q.delete();
    endtask

    task automatic idle_inputs();
        exe_to_pm_valid = 1'b0;
        exe_op          = '0;
        exe_exc         = '0;
        data_req_fire   = 1'b0;
        data_data_ok    = 1'b0;
        data_rdata      = '0;
        flush           = 1'b0;
    endtask

    task automatic present(input logic [OP_W-1:0] op, input logic [6:0] exc);
        exe_to_pm_valid = 1'b1;
        exe_op          = op;
        exe_exc         = exc;
        exe_pc          = $urandom;
        exe_inst        = $urandom;
        exe_value       = $urandom;
        exe_dest        = 5'($urandom);
    endtask

    // One clock: check all outputs against the model mid-cycle, then advance
    // the model with the inputs currently applied.
    task automatic cyc();
        logic ism, rdy, alw, tmv, ral;
        @(negedge clk);
        #1;
        ism = ((m_op[9:7] | m_op[6:4]) != 3'b000) && !m_exc[6];
        rdy = !ism || (m_q.size() != 0);
        alw = !m_valid || (rdy && mem_allowin);
        tmv = m_valid && rdy && !flush;
        ral = (m_out + m_q.size()) < DEPTH;
        chk("pm_valid", 64'(pm_valid), 64'(m_valid));
        chk("pm_allowin", 64'(pm_allowin), 64'(alw));
        chk("pm_to_mem_valid", 64'(pm_to_mem_valid), 64'(tmv));
        chk("data_req_allow", 64'(data_req_allow), 64'(ral));
        chk("pm_pc", 64'(pm_pc), 64'(m_pc));
        chk("pm_inst", 64'(pm_inst), 64'(m_inst));
        chk("pm_value", 64'(pm_value), 64'(m_value));
        chk("pm_op", 64'(pm_op), 64'(m_op));
        chk("pm_dest", 64'(pm_dest), 64'(m_dest));
        chk("pm_exc", 64'(pm_exc), 64'(m_exc));
        if (m_q.size() != 0) chk("pm_rdata", 64'(pm_rdata), 64'(m_q[0]));

        if (!resetn) begin
            model_reset();
        end else begin
            if (tmv && mem_allowin && ism) void'(m_q.pop_front());
            if (flush) begin
                m_disc  = m_disc + m_out + int'(data_req_fire) - int'(data_data_ok);
                m_valid = 1'b0;
                m_q.delete();
            end else begin
                if (data_data_ok) begin
                    if (m_disc > 0) m_disc--;
                    else m_q.push_back(data_rdata);
                end
                if (alw) begin
                    m_valid = exe_to_pm_valid;
                    if (exe_to_pm_valid) begin
                        m_pc    = exe_pc;
                        m_inst  = exe_inst;
                        m_value = exe_value;
                        m_op    = exe_op;
                        m_dest  = exe_dest;
                        m_exc   = exe_exc;
                    end
                end
            end
            m_out = m_out + int'(data_req_fire) - int'(data_data_ok);
        end
        @(posedge clk);
        #1;
    endtask

    logic [DATA_W-1:0] beats [4];

    initial begin
        beats[0] = 32'haaaa0001;
        beats[1] = 32'hbbbb0002;
        beats[2] = 32'hcccc0003;
        beats[3] = 32'hdddd0004;
        idle_inputs();
        exe_pc = '0; exe_inst = '0; exe_value = '0; exe_dest = '0;
        mem_allowin = 1'b1;
        resetn      = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        model_reset();
        cyc();
        resetn = 1'b1;

        // Reset state
        chk("rst_pm_valid", 64'(pm_valid), 64'd0);
        chk("rst_pm_pc", 64'(pm_pc), 64'hbfc00000);
        chk("rst_pm_rdata", 64'(pm_rdata), 64'd0);
        chk("rst_req_allow", 64'(data_req_allow), 64'd1);
        chk("rst_allowin", 64'(pm_allowin), 64'd1);

        // Single load: beat three cycles after the request
        present(OP_LOAD, 7'h00); data_req_fire = 1'b1; cyc();
        idle_inputs(); cyc(); cyc();
        data_data_ok = 1'b1; data_rdata = 32'h12345678; cyc();
        idle_inputs();
        chk("single_rdata", 64'(pm_rdata), 64'h12345678);
        chk("single_to_mem", 64'(pm_to_mem_valid), 64'd1);
        cyc();
        chk("single_done_valid", 64'(pm_valid), 64'd0);
        chk("single_done_allow", 64'(data_req_allow), 64'd1);

        // Four back-to-back loads with memory stage stalled
        mem_allowin = 1'b0;
        present(OP_LOAD, 7'h00); data_req_fire = 1'b1; cyc();
        for (int i = 0; i < 3; i++) cyc();
        data_req_fire = 1'b0;
        chk("b2b_allow_full", 64'(data_req_allow), 64'd0);
        for (int i = 0; i < 4; i++) begin
            data_data_ok = 1'b1; data_rdata = beats[i]; cyc();
        end
        data_data_ok = 1'b0;
        chk("b2b_allow_buffered", 64'(data_req_allow), 64'd0);
        mem_allowin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) present(OP_LOAD, 7'h00);
            else exe_to_pm_valid = 1'b0;
            chk("b2b_rdata", 64'(pm_rdata), 64'(beats[i]));
            chk("b2b_to_mem", 64'(pm_to_mem_valid), 64'd1);
            cyc();
        end
        idle_inputs();
        cyc();

        // Flush with three outstanding requests
        present(OP_LOAD, 7'h00); data_req_fire = 1'b1; cyc();
        exe_to_pm_valid = 1'b0; cyc(); cyc();
        data_req_fire = 1'b0; flush = 1'b1; present(OP_LOAD, 7'h00); cyc();
        idle_inputs();
        chk("flush_valid", 64'(pm_valid), 64'd0);
        chk("flush_disc", 64'(dut.disc_cnt_q), 64'd3);
        for (int i = 1; i <= 3; i++) begin
            data_data_ok = 1'b1; data_rdata = 32'hdead0000 + DATA_W'(i); cyc();
        end
        idle_inputs();
        present(OP_LOAD, 7'h00); data_req_fire = 1'b1; cyc();
        idle_inputs(); data_data_ok = 1'b1; data_rdata = 32'h0000beef; cyc();
        idle_inputs();
        chk("flush_new_rdata", 64'(pm_rdata), 64'h0000beef);
        chk("flush_new_to_mem", 64'(pm_to_mem_valid), 64'd1);
        cyc();

        // Flush coinciding with a beat and a new request, two outstanding
        data_req_fire = 1'b1; cyc(); cyc();
        data_data_ok = 1'b1; data_rdata = 32'h55555555; flush = 1'b1; cyc();
        idle_inputs();
        chk("flush_ok_disc", 64'(dut.disc_cnt_q), 64'd2);
        chk("flush_ok_out", 64'(dut.out_cnt_q), 64'd2);
        chk("flush_ok_fifo", 64'(dut.fifo_cnt_q), 64'd0);
        data_data_ok = 1'b1; data_rdata = 32'h66666666; cyc(); cyc();
        idle_inputs();
        present(OP_LOAD, 7'h00); data_req_fire = 1'b1; cyc();
        idle_inputs(); data_data_ok = 1'b1; data_rdata = 32'hcafe0001; cyc();
        idle_inputs();
        chk("flush_ok_rdata", 64'(pm_rdata), 64'hcafe0001);
        cyc();

        // Excepting load passes immediately and leaves the FIFO alone
        data_req_fire = 1'b1; cyc();
        idle_inputs(); data_data_ok = 1'b1; data_rdata = 32'h00000a0a; cyc();
        idle_inputs(); present(OP_LOAD, 7'h40); cyc();
        chk("exc_valid", 64'(pm_valid), 64'd1);
        chk("exc_to_mem", 64'(pm_to_mem_valid), 64'd1);
        present(OP_LOAD, 7'h00); cyc();
        idle_inputs();
        chk("exc_fifo_kept", 64'(pm_rdata), 64'h00000a0a);
        chk("exc_then_load", 64'(pm_to_mem_valid), 64'd1);
        cyc();

        // Reset with two requests outstanding
        present(OP_STORE, 7'h00); data_req_fire = 1'b1; cyc();
        exe_to_pm_valid = 1'b0; cyc();
        idle_inputs(); resetn = 1'b0; cyc();
        resetn = 1'b1;
        chk("midrst_valid", 64'(pm_valid), 64'd0);
        chk("midrst_pc", 64'(pm_pc), 64'hbfc00000);
        chk("midrst_allow", 64'(data_req_allow), 64'd1);
        chk("midrst_out", 64'(dut.out_cnt_q), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int unsigned r;
            idle_inputs();
            r = $urandom_range(0, 3);
            if ($urandom_range(0, 2) != 0) begin
                present((r == 0) ? OP_ALU : (r == 1) ? OP_STORE : OP_LOAD,
                        ($urandom_range(0, 7) == 0) ? 7'h40 : 7'h00);
            end
            data_req_fire = ((m_out + m_q.size()) < DEPTH) && ($urandom_range(0, 1) == 1);
            data_data_ok  = (m_out > 0) && ($urandom_range(0, 2) == 0);
            data_rdata    = $urandom;
            flush         = (m_disc == 0) && ($urandom_range(0, 19) == 0);
            mem_allowin   = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
